stage_fetch_handshake: RTL and testbench

- Instruction-fetch stage for the 5-stage MIPS pipeline, driving the IF→DEC pipeline latch.
- Owns the PC and fetches through a req/ack instruction-memory port that tolerates zero or more wait states.
- Accepts branch redirects from the MEM stage and a stall from hazard logic.
- Presents instr/pcplus4 plus a valid flag; flushed slots carry NOP (32'h0).

---
 rtl/stage_fetch_handshake.sv | 133 +++++++++++++
 tb/tb_stage_fetch_handshake.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_fetch_handshake.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port and
// drives the IF->DEC latch, with branch redirect and a one-word overflow buffer.
module stage_fetch_handshake #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic [31:0] pcbranch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] pend_q;
    logic [31:0] instr_q;
    logic [31:0] pcplus4_q;
    logic        valid_q;

    logic [31:0] target;
    logic [31:0] addr_inc;
    logic        out_ready;
    logic        consume;

    assign target    = {pcbranch[31:2], 2'b00};
    assign addr_inc  = req_addr_q + 32'd4;
    assign out_ready = !valid_q || !stall;
    assign consume   = valid_q && !stall;

    // Reset gates the request directly so it drops without waiting for an edge.
    assign imem_req  = !reset && ((state_q == S_REQ) || (state_q == S_DROP));
    assign imem_addr = req_addr_q;
    assign instr     = instr_q;
    assign pcplus4   = pcplus4_q;
    assign valid     = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            pend_q     <= 32'h0;
            instr_q    <= 32'h0;
            pcplus4_q  <= 32'h0;
            valid_q    <= 1'b0;
        end else if (pcsrc) begin
            // Redirect wins over stall and ack; a request already on the bus
            // without its ack must still be completed (DROP) before retargeting.
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pend_q  <= 32'h0;
            pc_q    <= target;
            case (state_q)
                S_REQ: begin
                    if (imem_ack) begin
                        req_addr_q <= target;
                    end else begin
                        state_q <= S_DROP;
                    end
                end
                S_HOLD: begin
                    req_addr_q <= target;
                    state_q    <= S_REQ;
                end
                default: begin
                    if (imem_ack) begin
                        req_addr_q <= target;
                        state_q    <= S_REQ;
                    end
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ack && out_ready) begin
                        instr_q    <= imem_rdata;
                        pcplus4_q  <= addr_inc;
                        valid_q    <= 1'b1;
                        req_addr_q <= addr_inc;
                        pc_q       <= addr_inc;
                    end else if (imem_ack) begin
                        pend_q     <= imem_rdata;
                        req_addr_q <= addr_inc;
                        pc_q       <= addr_inc;
                        state_q    <= S_HOLD;
                    end else if (consume) begin
                        valid_q <= 1'b0;
                        instr_q <= 32'h0;
                    end
                end
                S_HOLD: begin
                    // req_addr already points past the buffered word, so it is its pc+4.
                    if (!stall) begin
                        instr_q   <= pend_q;
                        pcplus4_q <= req_addr_q;
                        valid_q   <= 1'b1;
                        pend_q    <= 32'h0;
                        state_q   <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (consume) begin
                        valid_q <= 1'b0;
                        instr_q <= 32'h0;
                    end
                    if (imem_ack) begin
                        req_addr_q <= pc_q;
                        state_q    <= S_REQ;
                    end
                end
                default: begin
                    state_q    <= S_REQ;
                    req_addr_q <= pc_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_fetch_handshake.sv
// Directed bench for stage_fetch_handshake: behavioural memory returning rdata = addr
// with programmable wait states, plus a second instance exercising PC wrap-around.
module tb_stage_fetch_handshake;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] pcbranch = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pcplus4;
    logic        w_valid;
    logic        tie0 = 1'b0;
    logic [31:0] tie0_32 = 32'h0;

    int          wait_n = 0;
    int          wcnt;
    logic        ack_block = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && !ack_block && (wcnt >= wait_n);
    assign imem_rdata = imem_addr;

    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    stage_fetch_handshake #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc), .pcbranch(pcbranch),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .pcplus4(pcplus4), .valid(valid)
    );

    stage_fetch_handshake #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .stall(tie0), .pcsrc(tie0), .pcbranch(tie0_32),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req),
        .imem_rdata(w_addr), .instr(w_instr), .pcplus4(w_pcplus4), .valid(w_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values and zero-wait streaming
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pcplus4", pcplus4, 0);
        reset = 1'b0;
        #1;
        chk("zw_req0", imem_req, 1);
        chk("zw_addr0", imem_addr, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("zw_valid1", valid, 1);
        chk("zw_instr1", instr, 32'h0);
        chk("zw_pcp1", pcplus4, 32'h4);
        chk("zw_addr1", imem_addr, 32'h4);
        chk("wrap_pcp", w_pcplus4, 32'h0);
        chk("wrap_instr", w_instr, 32'hFFFF_FFFC);
        chk("wrap_addr1", w_addr, 32'h0);
        tick();
        chk("zw_instr2", instr, 32'h4);
        chk("zw_pcp2", pcplus4, 32'h8);
        tick();
        chk("zw_instr3", instr, 32'h8);
        chk("zw_valid3", valid, 1);

        // Two wait states
        reset = 1'b1;
        tick();
        wait_n = 2;
        reset = 1'b0;
        #1;
        chk("ws_addr_a", imem_addr, 32'h0);
        chk("ws_ack_a", imem_ack, 0);
        tick();
        chk("ws_addr_b", imem_addr, 32'h0);
        chk("ws_valid_b", valid, 0);
        tick();
        chk("ws_addr_c", imem_addr, 32'h0);
        chk("ws_ack_c", imem_ack, 1);
        chk("ws_valid_c", valid, 0);
        tick();
        chk("ws_valid_d", valid, 1);
        chk("ws_instr_d", instr, 32'h0);
        chk("ws_addr_d", imem_addr, 32'h4);
        tick();
        chk("ws_drain_valid", valid, 0);
        chk("ws_drain_instr", instr, 32'h0);

        // Stall with zero-wait ack: overflow buffer and HOLD
        reset = 1'b1;
        tick();
        wait_n = 0;
        reset = 1'b0;
        tick();
        chk("st_valid0", valid, 1);
        stall = 1'b1;
        tick();
        chk("st_req_hold", imem_req, 0);
        chk("st_instr_h1", instr, 32'h0);
        chk("st_pcp_h1", pcplus4, 32'h4);
        tick();
        tick();
        chk("st_instr_h3", instr, 32'h0);
        chk("st_valid_h3", valid, 1);
        chk("st_req_h3", imem_req, 0);
        stall = 1'b0;
        tick();
        chk("st_buf_instr", instr, 32'h4);
        chk("st_buf_pcp", pcplus4, 32'h8);
        chk("st_resume_req", imem_req, 1);
        chk("st_resume_addr", imem_addr, 32'h8);
        tick();
        chk("st_next_instr", instr, 32'h8);

        // Redirect while a request to 0x10 waits
        tick();
        chk("rd_addr_pre", imem_addr, 32'h10);
        ack_block = 1'b1;
        pcsrc = 1'b1;
        pcbranch = 32'h0000_0103;
        tick();
        pcsrc = 1'b0;
        chk("rd_valid", valid, 0);
        chk("rd_instr", instr, 32'h0);
        chk("rd_drop_req", imem_req, 1);
        chk("rd_drop_addr", imem_addr, 32'h10);
        tick();
        chk("rd_drop_addr2", imem_addr, 32'h10);
        ack_block = 1'b0;
        #1;
        chk("rd_drop_ack", imem_ack, 1);
        tick();
        chk("rd_stale_valid", valid, 0);
        chk("rd_stale_instr", instr, 32'h0);
        chk("rd_new_addr", imem_addr, 32'h100);
        tick();
        chk("rd_tgt_instr", instr, 32'h100);
        chk("rd_tgt_pcp", pcplus4, 32'h104);
        chk("rd_tgt_valid", valid, 1);

        // Redirect together with stall flushes a valid output
        stall = 1'b1;
        pcsrc = 1'b1;
        pcbranch = 32'h0000_0200;
        tick();
        stall = 1'b0;
        pcsrc = 1'b0;
        chk("rs_valid", valid, 0);
        chk("rs_instr", instr, 32'h0);
        chk("rs_addr", imem_addr, 32'h200);
        tick();
        chk("rs_tgt_instr", instr, 32'h200);

        // Redirect out of HOLD
        stall = 1'b1;
        tick();
        chk("rh_hold_req", imem_req, 0);
        pcsrc = 1'b1;
        pcbranch = 32'h0000_0300;
        tick();
        pcsrc = 1'b0;
        stall = 1'b0;
        chk("rh_valid", valid, 0);
        chk("rh_req", imem_req, 1);
        chk("rh_addr", imem_addr, 32'h300);
        tick();
        chk("rh_instr", instr, 32'h300);

        // Reset asserted mid-wait, outputs return without a clock edge
        wait_n = 2;
        stall = 1'b1;
        tick();
        chk("mr_valid_pre", valid, 1);
        chk("mr_req_pre", imem_req, 1);
        chk("mr_ack_pre", imem_ack, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_req", imem_req, 0);
        chk("mr_valid", valid, 0);
        chk("mr_instr", instr, 32'h0);
        chk("mr_pcp", pcplus4, 32'h0);
        chk("mr_addr", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
